camera_mcu_ingester: RTL and testbench

Parametrised successor to the HM01B0 ingester. Samples an 8-bit parallel camera (pixclk/hsync/vsync) in the system clock domain and scatters pixels into NUM_EBR block RAMs in 8x8 MCU order, double-buffered per MCU row. Adds frame-sync tracking, line-length checking, and a row-ready/ack handshake so the downstream JPEG DCT stage knows when a back buffer is complete.

---
 rtl/camera_mcu_ingester.sv | 242 ++++++++++++++++++++++++
 tb/tb_camera_mcu_ingester.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_mcu_ingester.sv
// Parallel-camera ingester: synchronises an 8-bit pixel bus into the system
// clock domain and scatters pixels into NUM_EBR block RAMs in 8x8 MCU order,
// double-buffered per MCU row, with a row-ready/ack handshake to the consumer.
module camera_mcu_ingester #(
  parameter int         WIDTH_PIX     = 320,
  parameter int         HEIGHT_PIX    = 240,
  parameter int         NUM_EBR       = 5,
  parameter int         EBR_SIZE      = 512,
  parameter logic [7:0] PIX_OFFSET    = 8'h80,
  parameter bit         PIXCLK_RISING = 1'b1,
  localparam int BLK_W  = (NUM_EBR > 1) ? $clog2(NUM_EBR) : 1,
  localparam int ADDR_W = $clog2(EBR_SIZE),
  localparam int ROW_W  = (HEIGHT_PIX / 8 > 1) ? $clog2(HEIGHT_PIX / 8) : 1
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              cam_pixclk,
  input  logic [7:0]        cam_pixdata,
  input  logic              cam_hsync,
  input  logic              cam_vsync,
  output logic              frontbuffer_select,
  output logic [BLK_W-1:0]  output_block_select,
  output logic [ADDR_W-1:0] output_write_addr,
  output logic [7:0]        output_pixval,
  output logic              wren,
  output logic              row_ready,
  input  logic              row_ack,
  output logic [ROW_W-1:0]  row_index,
  output logic              frame_done,
  output logic              overflow,
  output logic              line_error,
  input  logic              clear_errors
);

  localparam int SLOTS  = WIDTH_PIX / (8 * NUM_EBR);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  // one extra code above WIDTH_PIX marks a line that ran long
  localparam int COL_W  = $clog2(WIDTH_PIX + 2);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  // bit0 = stage 1, bit1 = stage 2, bit2 = previous stage-2 value for edges
  logic [2:0] pc_s, hs_s, vs_s;
  logic [7:0] pd_s1, pd_s2;
  logic [1:0] settle_q;
  logic       settled, pix_edge, vs_rise, vs_fall, hs_fall;

  state_t            state_q, state_d;
  logic [2:0]        px_q, px_d, py_q, py_d;
  logic [BLK_W-1:0]  blk_q, blk_d, oblk_q, oblk_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  mcuy_q, mcuy_d, ridx_q, ridx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        pix_q, pix_d;
  logic              wren_q, wren_d, fb_q, fb_d, rr_q, rr_d, fd_q, fd_d;
  logic              ovf_q, ovf_d, lerr_q, lerr_d;
  logic              eol, row_done, ovf_set, lerr_set;

  // Edges are ignored until the sync chain holds real samples, so a frame
  // already in progress when reset releases is not mistaken for a new one.
  assign settled  = &settle_q;
  assign pix_edge = settled & (PIXCLK_RISING ? (pc_s[1] & ~pc_s[2]) : (~pc_s[1] & pc_s[2]));
  assign vs_rise  = settled & vs_s[1] & ~vs_s[2];
  assign vs_fall  = settled & ~vs_s[1] & vs_s[2];
  assign hs_fall  = settled & ~hs_s[1] & hs_s[2];

  // Two-flop synchronisers plus edge-detect history and post-reset settle count
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pc_s     <= '0;
      hs_s     <= '0;
      vs_s     <= '0;
      pd_s1    <= '0;
      pd_s2    <= '0;
      settle_q <= '0;
    end else begin
      pc_s     <= {pc_s[1:0], cam_pixclk};
      hs_s     <= {hs_s[1:0], cam_hsync};
      vs_s     <= {vs_s[1:0], cam_vsync};
      pd_s1    <= cam_pixdata;
      pd_s2    <= pd_s1;
      settle_q <= settled ? settle_q : settle_q + 2'd1;
    end
  end

  // Next state: write launch, MCU counter advance, line check, row handshake, FSM
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    blk_d    = blk_q;
    slot_d   = slot_q;
    col_d    = col_q;
    mcuy_d   = mcuy_q;
    wren_d   = 1'b0;
    pix_d    = pix_q;
    addr_d   = addr_q;
    oblk_d   = oblk_q;
    fb_d     = fb_q;
    ridx_d   = ridx_q;
    rr_d     = rr_q;
    fd_d     = 1'b0;
    eol      = 1'b0;
    row_done = 1'b0;
    ovf_set  = 1'b0;
    lerr_set = 1'b0;

    if (state_q == ACTIVE && pix_edge && hs_s[1]) begin
      if (col_q < COL_W'(WIDTH_PIX)) begin
        wren_d = 1'b1;
        pix_d  = pd_s2 + PIX_OFFSET;
        addr_d = ADDR_W'({slot_q, py_q, px_q});
        oblk_d = blk_q;
      end else begin
        col_d = COL_W'(WIDTH_PIX + 1);
      end
    end

    // counters step the cycle after each write
    if (wren_q) begin
      col_d = col_q + COL_W'(1);
      if (px_q == 3'd7) begin
        px_d = 3'd0;
        if (blk_q == BLK_W'(NUM_EBR - 1)) begin
          blk_d  = '0;
          slot_d = slot_q + SLOT_W'(1);
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end else begin
        px_d = px_q + 3'd1;
      end
      if (col_q == COL_W'(WIDTH_PIX - 1)) eol = 1'b1;
    end

    // a short line still closes out its MCU line; surplus pixels were dropped
    if (state_q == ACTIVE && hs_fall) begin
      if (col_d != COL_W'(WIDTH_PIX)) lerr_set = 1'b1;
      if (col_d <  COL_W'(WIDTH_PIX)) eol = 1'b1;
      col_d = '0;
    end

    if (eol) begin
      px_d   = 3'd0;
      blk_d  = '0;
      slot_d = '0;
      py_d   = py_q + 3'd1;
      if (py_q == 3'd7) row_done = 1'b1;
    end

    if (row_done) begin
      fb_d   = ~fb_q;
      ridx_d = mcuy_q;
      rr_d   = 1'b1;
      // the camera cannot be stalled, so an unconsumed buffer is overwritten
      if (rr_q && !row_ack) ovf_set = 1'b1;
      mcuy_d = mcuy_q + ROW_W'(1);
      if (mcuy_q == ROW_W'(HEIGHT_PIX / 8 - 1)) begin
        fd_d    = 1'b1;
        state_d = DROP;
        mcuy_d  = '0;
      end
    end else if (row_ack) begin
      rr_d = 1'b0;
    end

    case (state_q)
      IDLE:    if (vs_rise) state_d = ACTIVE;
      ACTIVE:  if (vs_fall) state_d = IDLE;
      DROP:    if (vs_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // frame start (or restart) clears position but keeps the buffer half
    if ((state_q == IDLE || state_q == ACTIVE) && vs_rise) begin
      state_d = ACTIVE;
      px_d    = 3'd0;
      py_d    = 3'd0;
      blk_d   = '0;
      slot_d  = '0;
      col_d   = '0;
      mcuy_d  = '0;
    end

    ovf_d  = (ovf_q  & ~clear_errors) | ovf_set;
    lerr_d = (lerr_q & ~clear_errors) | lerr_set;
  end

  // State and output registers
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      blk_q   <= '0;
      slot_q  <= '0;
      col_q   <= '0;
      mcuy_q  <= '0;
      wren_q  <= 1'b0;
      pix_q   <= '0;
      addr_q  <= '0;
      oblk_q  <= '0;
      fb_q    <= 1'b0;
      ridx_q  <= '0;
      rr_q    <= 1'b0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      blk_q   <= blk_d;
      slot_q  <= slot_d;
      col_q   <= col_d;
      mcuy_q  <= mcuy_d;
      wren_q  <= wren_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      oblk_q  <= oblk_d;
      fb_q    <= fb_d;
      ridx_q  <= ridx_d;
      rr_q    <= rr_d;
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
    end
  end

  assign frontbuffer_select  = fb_q;
  assign output_block_select = oblk_q;
  assign output_write_addr   = addr_q;
  assign output_pixval       = pix_q;
  assign wren                = wren_q;
  assign row_ready           = rr_q;
  assign row_index           = ridx_q;
  assign frame_done          = fd_q;
  assign overflow            = ovf_q;
  assign line_error          = lerr_q;

endmodule

// File: tb/tb_camera_mcu_ingester.sv
// Bench for camera_mcu_ingester using a reduced geometry (64x16, 2 EBRs,
// falling-edge capture) so several whole frames fit in a short run.
module tb_camera_mcu_ingester;

  localparam int W  = 64;
  localparam int H  = 16;
  localparam int NE = 2;

  logic       clock = 1'b0;
  logic       nreset, cam_pixclk, cam_hsync, cam_vsync, clear_errors;
  logic [7:0] cam_pixdata;
  logic       row_ack = 1'b0;
  logic       frontbuffer_select, wren, row_ready, frame_done, overflow, line_error;
  logic [0:0] output_block_select;
  logic [7:0] output_write_addr, output_pixval;
  logic [0:0] row_index;
  logic [23:0] outs;

  camera_mcu_ingester #(
    .WIDTH_PIX(W), .HEIGHT_PIX(H), .NUM_EBR(NE), .EBR_SIZE(256),
    .PIX_OFFSET(8'h80), .PIXCLK_RISING(1'b0)
  ) dut (
    .clock(clock), .nreset(nreset), .cam_pixclk(cam_pixclk), .cam_pixdata(cam_pixdata),
    .cam_hsync(cam_hsync), .cam_vsync(cam_vsync), .frontbuffer_select(frontbuffer_select),
    .output_block_select(output_block_select), .output_write_addr(output_write_addr),
    .output_pixval(output_pixval), .wren(wren), .row_ready(row_ready), .row_ack(row_ack),
    .row_index(row_index), .frame_done(frame_done), .overflow(overflow),
    .line_error(line_error), .clear_errors(clear_errors)
  );

  always #5 clock = ~clock;

  assign outs = {frontbuffer_select, output_block_select, output_write_addr, output_pixval,
                 wren, row_ready, row_index, frame_done, overflow, line_error};

  typedef struct { int blk; int addr; int val; int x; int y; } wr_t;
  typedef struct { int npix; int pat; bit exp_lerr; bit clr; int exp_wr; } line_vec_t;

  wr_t sb[$];
  int  n_checks = 0, n_fail = 0;
  int  wcnt = 0, fdcnt = 0, rrcnt = 0;
  int  ack_mode = 0, ack_target = -1;
  int  cap_blk = -1, cap_addr = -1, cap_val = -1;
  logic rr_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [7:0] patval(input int pat, input int x);
    case (pat)
      0:       return x[7:0];
      1:       return ~x[7:0];
      2:       return 8'($urandom_range(0, 255));
      3:       return 8'h7F;
      default: return 8'h80;
    endcase
  endfunction

  // Expected placement of pixel (x,y) within the MCU-row buffer
  task automatic push_exp(input int x, input int y, input logic [7:0] d);
    wr_t e;
    int  dv;
    dv = int'(d);
    if (x < W) begin
      e.blk  = (x / 8) % NE;
      e.addr = (x / (8 * NE)) * 64 + (y % 8) * 8 + (x % 8);
      e.val  = (dv + 128) % 256;
      e.x    = x;
      e.y    = y;
      sb.push_back(e);
    end
  endtask

  task automatic send_pix(input logic [7:0] d);
    cam_pixdata = d;
    wait_clk(3);
    cam_pixclk = 1'b0;
    wait_clk(3);
    cam_pixclk = 1'b1;
  endtask

  task automatic send_line(input int y, input int npix, input int pat, input bit push);
    logic [7:0] d;
    cam_hsync = 1'b1;
    wait_clk(3);
    for (int x = 0; x < npix; x++) begin
      d = patval(pat, x);
      if (push) push_exp(x, y, d);
      send_pix(d);
    end
    wait_clk(3);
    cam_hsync = 1'b0;
    wait_clk(6);
  endtask

  // Scoreboard: every write strobe pops and checks the oldest expected pixel
  always @(negedge clock) begin
    wr_t e;
    if (nreset === 1'b1) begin
      if (wren) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wren: addr %0d with no pixel expected", output_write_addr);
        end else begin
          e = sb.pop_front();
          check("wr_block", int'(output_block_select), e.blk);
          check("wr_addr",  int'(output_write_addr),   e.addr);
          check("wr_val",   int'(output_pixval),       e.val);
          if (e.x == 13 && e.y == 2) begin
            cap_blk  = int'(output_block_select);
            cap_addr = int'(output_write_addr);
            cap_val  = int'(output_pixval);
          end
        end
        wcnt++;
      end
      if (frame_done) fdcnt++;
      if (row_ready && !rr_prev) rrcnt++;
      rr_prev = row_ready;
    end
    row_ack = (ack_mode == 2) || (ack_mode == 1 && wren && wcnt == ack_target);
  end

  line_vec_t tbl[16];
  int base, fd0, rr0;

  initial begin
    tbl[0]  = '{64, 0, 1'b0, 1'b0, 64};
    tbl[1]  = '{64, 1, 1'b0, 1'b0, 64};
    tbl[2]  = '{64, 0, 1'b0, 1'b0, 64};
    tbl[3]  = '{50, 2, 1'b1, 1'b1, 50};   // short line
    tbl[4]  = '{64, 3, 1'b0, 1'b0, 64};
    tbl[5]  = '{70, 0, 1'b1, 1'b1, 64};   // long line, surplus dropped
    tbl[6]  = '{64, 4, 1'b0, 1'b0, 64};
    tbl[7]  = '{64, 2, 1'b0, 1'b0, 64};
    tbl[8]  = '{64, 0, 1'b0, 1'b0, 64};
    tbl[9]  = '{7,  1, 1'b1, 1'b0, 7};    // short, flag left set
    tbl[10] = '{64, 2, 1'b1, 1'b1, 64};   // flag still sticky
    tbl[11] = '{64, 1, 1'b0, 1'b0, 64};
    tbl[12] = '{64, 3, 1'b0, 1'b0, 64};
    tbl[13] = '{64, 4, 1'b0, 1'b0, 64};
    tbl[14] = '{64, 0, 1'b0, 1'b0, 64};
    tbl[15] = '{64, 2, 1'b0, 1'b0, 64};

    nreset = 1'b0; cam_pixclk = 1'b1; cam_hsync = 1'b0; cam_vsync = 1'b0;
    cam_pixdata = 8'h00; clear_errors = 1'b0;
    wait_clk(3);
    check("reset_outputs", int'(outs), 0);
    nreset = 1'b1;
    wait_clk(5);

    // reset in the middle of a line; the rest of that frame must be skipped
    cam_vsync = 1'b1;
    wait_clk(6);
    cam_hsync = 1'b1;
    wait_clk(3);
    for (int x = 0; x < 10; x++) begin
      push_exp(x, 0, 8'(x));
      send_pix(8'(x));
    end
    wait_clk(4);
    check("pre_reset_wrens", wcnt, 10);
    nreset = 1'b0;
    #1;
    check("midline_reset_outputs", int'(outs), 0);
    wait_clk(2);
    nreset = 1'b1;
    base = wcnt;
    for (int x = 10; x < 40; x++) send_pix(8'(x));
    wait_clk(3);
    cam_hsync = 1'b0;
    wait_clk(6);
    send_line(1, W, 0, 1'b0);
    cam_vsync = 1'b0;
    wait_clk(6);
    check("no_wren_after_reset", wcnt - base, 0);

    // frame 1: table of lines, consumer acks continuously
    fd0 = fdcnt; rr0 = rrcnt; ack_mode = 2;
    cam_vsync = 1'b1;
    wait_clk(6);
    for (int i = 0; i < 16; i++) begin
      base = wcnt;
      send_line(i, tbl[i].npix, tbl[i].pat, 1'b1);
      check("line_wrens", wcnt - base, tbl[i].exp_wr);
      check("line_error", int'(line_error), int'(tbl[i].exp_lerr));
      if (tbl[i].clr) begin
        clear_errors = 1'b1;
        wait_clk(1);
        clear_errors = 1'b0;
        wait_clk(1);
        check("line_error_cleared", int'(line_error), 0);
      end
    end
    wait_clk(4);
    cam_vsync = 1'b0;
    wait_clk(6);
    ack_mode = 0;
    check("f1_frame_done", fdcnt - fd0, 1);
    check("f1_row_ready_count", rrcnt - rr0, 2);
    check("f1_overflow", int'(overflow), 0);
    check("f1_fb", int'(frontbuffer_select), 0);
    check("px13_y2_block", cap_blk, 1);
    check("px13_y2_addr", cap_addr, 21);
    check("px13_y2_val", cap_val, 8'h8D);

    // frame 2: no ack, second row overruns the back buffer
    fd0 = fdcnt;
    cam_vsync = 1'b1;
    wait_clk(6);
    for (int y = 0; y < 8; y++) send_line(y, W, 0, 1'b1);
    check("f2_row0_ready", int'(row_ready), 1);
    check("f2_row0_index", int'(row_index), 0);
    check("f2_row0_fb", int'(frontbuffer_select), 1);
    check("f2_row0_overflow", int'(overflow), 0);
    for (int y = 8; y < 16; y++) send_line(y, W, 1, 1'b1);
    wait_clk(4);
    cam_vsync = 1'b0;
    wait_clk(6);
    check("f2_overflow", int'(overflow), 1);
    check("f2_row1_index", int'(row_index), 1);
    check("f2_fb", int'(frontbuffer_select), 0);
    check("f2_frame_done", fdcnt - fd0, 1);
    clear_errors = 1'b1;
    wait_clk(1);
    clear_errors = 1'b0;
    wait_clk(1);
    check("f2_overflow_cleared", int'(overflow), 0);
    check("f2_ready_held", int'(row_ready), 1);
    ack_mode = 2;
    wait_clk(3);
    ack_mode = 0;
    wait_clk(3);
    check("f2_ready_acked", int'(row_ready), 0);

    // frame 3: ack lands in the very cycle the second row completes
    fd0 = fdcnt;
    cam_vsync = 1'b1;
    wait_clk(6);
    for (int y = 0; y < 8; y++) send_line(y, W, 2, 1'b1);
    check("f3_row0_ready", int'(row_ready), 1);
    ack_target = wcnt + 8 * W;
    ack_mode = 1;
    for (int y = 8; y < 16; y++) send_line(y, W, 0, 1'b1);
    wait_clk(4);
    cam_vsync = 1'b0;
    wait_clk(6);
    ack_mode = 0;
    check("f3_ready_kept", int'(row_ready), 1);
    check("f3_no_overflow", int'(overflow), 0);
    check("f3_row1_index", int'(row_index), 1);
    check("f3_frame_done", fdcnt - fd0, 1);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
